// File: rtl/aes_stream_sequencer.sv
// aes_stream_sequencer: gathers four host words, runs the AES core and streams the result back out
module aes_stream_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [127:0] aes_din,
  output logic         aes_start,
  input  logic         aes_done,
  output logic         sr_load,
  output logic         sr_shift,
  output logic         sr_cs,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);
  typedef enum logic [2:0] {IDLE, GATHER, START, WAIT_CORE, LOAD, STREAM} state_t;
  localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT - 1);
  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [15:0]  timer_q, timer_d;
  logic [127:0] din_q, din_d;
  logic         err_q, err_d;
  // state, counters, assembled block and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      timer_q <= 16'd0;
      din_q   <= 128'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end
  // next state and handshake strobes; cnt_q counts input words, then output words
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    err_d     = err_q;
    in_ready  = (state_q == IDLE || state_q == GATHER) && !abort;
    aes_start = state_q == START && !abort;
    sr_load   = state_q == LOAD && !abort;
    sr_cs     = state_q == LOAD || state_q == STREAM;
    out_valid = state_q == STREAM;
    out_last  = out_valid && cnt_q == 2'd3;
    sr_shift  = out_valid && out_ready && !abort;
    case (state_q)
      IDLE, GATHER: if (in_valid && in_ready) begin
        din_d[{~cnt_q, 5'd0} +: 32] = in_data;
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? START : GATHER;
        err_d   = state_q == IDLE ? 1'b0 : err_q;
      end
      START:     state_d = WAIT_CORE;
      WAIT_CORE: begin
        state_d = aes_done ? LOAD : timer_q == TIMER_MAX ? IDLE : WAIT_CORE;
        err_d   = err_q || (!aes_done && timer_q == TIMER_MAX);
      end
      LOAD:      state_d = STREAM;
      STREAM: if (sr_shift) begin
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? IDLE : STREAM;
      end
      default:   state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
    end
    timer_d = state_q == WAIT_CORE && state_d == WAIT_CORE ? timer_q + 16'd1 : 16'd0;
  end
  assign aes_din = din_q;
  assign busy    = state_q != IDLE;
  assign err     = err_q;
endmodule

// File: tb/tb_aes_stream_sequencer.sv
// tb_aes_stream_sequencer: scoreboard bench with AES core and output shift-register models
module tb_aes_stream_sequencer;
  localparam int TO = 8;
  localparam logic [127:0] KAT_PT = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] KAT_CT = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, abort = 1'b0, aes_done = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic in_ready, aes_start, sr_load, sr_shift, sr_cs, out_valid, out_last, busy, err;
  logic [127:0] aes_din;
  logic [127:0] aes_dout = 128'd0, sr = 128'd0;
  logic [31:0] data_out;
  int n_cmp = 0, n_bad = 0, n_load = 0, core_lat = 5, cd = -1;
  bit core_mute = 1'b0, rand_bp = 1'b0, b2b = 1'b0;
  logic [127:0] blk_q[$];
  logic [32:0] out_q[$];
  logic [32:0] e;

  assign data_out = sr[127:96];
  always #5 clk = ~clk;

  aes_stream_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .aes_din(aes_din), .aes_start(aes_start), .aes_done(aes_done),
    .sr_load(sr_load), .sr_shift(sr_shift), .sr_cs(sr_cs), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .err(err)
  );

  // stand-in cipher: the known FIPS-197 vector, otherwise an arbitrary reversible mix
  function automatic logic [127:0] core_fn(input logic [127:0] b);
    return b == KAT_PT ? KAT_CT : {b[95:0], b[127:96]} ^ {4{32'h9E3779B9}};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    check(name, 128'(got), 128'(want));
  endtask

  // 128-to-32 shift register seen by the sequencer
  always @(posedge clk) if (sr_cs) begin
    if (sr_load) sr <= aes_dout;
    else if (sr_shift) sr <= {sr[95:0], 32'h0};
  end

  // AES core: answers core_lat cycles after the start pulse, holds dout until the next start
  always @(negedge clk) begin
    aes_done = 1'b0;
    if (reset) cd = -1;
    else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        aes_done = 1'b1;
        cd = -1;
      end
    end
    if (!reset && aes_start) begin
      aes_dout = core_fn(aes_din);
      cd = core_mute ? -1 : core_lat;
    end
  end

  // random output backpressure
  always @(posedge clk) begin
    #2;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // monitor: pops the scoreboard on every start pulse and output handshake
  always @(negedge clk) begin
    if (aes_start) begin
      if (blk_q.size() == 0) check("unexpected_start", aes_din, 128'd0 - 128'd1);
      else check("aes_din", aes_din, blk_q.pop_front());
    end
    if (sr_load) n_load++;
    check1("shift_rule", sr_shift, out_valid && out_ready && !abort);
    check1("load_shift_excl", sr_load && sr_shift, 1'b0);
    if (!abort) check1("sr_cs", sr_cs, sr_load || out_valid);
    if (b2b) check("b2b_idle", 128'({in_ready, busy}), 128'(2'b10));
    b2b = 1'b0;
    if (out_valid && out_ready && !abort) begin
      if (out_q.size() == 0) check("unexpected_word", 128'({out_last, data_out}), 128'd0 - 128'd1);
      else begin
        e = out_q.pop_front();
        check("out_word", 128'({out_last, data_out}), 128'(e));
      end
      b2b = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check1("accept", acc, 1'b1);
  endtask

  task automatic finish_block(input logic [127:0] b, input bit with_out);
    logic [127:0] r;
    r = core_fn(b);
    blk_q.push_back(b);
    if (with_out) for (int k = 0; k < 4; k++) out_q.push_back({k == 3, 32'(r >> (32 * (3 - k)))});
    @(negedge clk);
    check1("start_after_4th", aes_start, 1'b1);
    tick();
  endtask

  task automatic send_block(input logic [127:0] b, input int gap_max, input bit with_out);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      send_word(32'(b >> (32 * (3 - k))));
    end
    finish_block(b, with_out);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = out_q.size() == 0 && !busy;
    end
    check1("drain", ok, 1'b1);
    tick();
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    check1("wait_valid", ok, 1'b1);
    tick();
  endtask

  task automatic check_reset_vals(input string name);
    check(name, 128'({in_ready, aes_start, sr_load, sr_shift, sr_cs, out_valid, out_last, busy, err}),
          128'(9'b1_0000_0000));
    check({name, "_din"}, aes_din, 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] b, r;
    int nl;
    repeat (2) tick();
    @(negedge clk);
    check_reset_vals("reset");
    tick();
    reset = 1'b0;
    // basic block with the known vector, done 5 cycles after start
    out_ready = 1'b1;
    core_lat = 5;
    send_block(KAT_PT, 0, 1'b1);
    repeat (5) tick();
    @(negedge clk);
    check("load_cycle", 128'({sr_load, out_valid}), 128'(2'b10));
    tick();
    @(negedge clk);
    check1("first_valid", out_valid, 1'b1);
    wait_done();
    // output backpressure on the second word
    core_lat = 3;
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    r = core_fn(b);
    send_block(b, 0, 1'b1);
    wait_valid();
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", 128'({out_valid, sr_shift, data_out}), 128'({2'b10, r[95:64]}));
      tick();
    end
    out_ready = 1'b1;
    wait_done();
    // input gaps 1,0,0,1,1,0,1
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_word(b[127:96]);
    repeat (2) tick();
    send_word(b[95:64]);
    send_word(b[63:32]);
    tick();
    send_word(b[31:0]);
    finish_block(b, 1'b1);
    wait_done();
    // timeout: core never answers
    core_mute = 1'b1;
    nl = n_load;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b0);
    repeat (7) tick();
    @(negedge clk);
    check1("err_before_timeout", err, 1'b0);
    tick();
    @(negedge clk);
    check("timeout_err_idle", 128'({err, busy}), 128'(2'b10));
    check("timeout_no_load", 128'(n_load), 128'(nl));
    tick();
    core_mute = 1'b0;
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_word(b[127:96]);
    @(negedge clk);
    check1("err_cleared", err, 1'b0);
    tick();
    send_word(b[95:64]);
    send_word(b[63:32]);
    send_word(b[31:0]);
    finish_block(b, 1'b1);
    wait_done();
    // done on the same cycle the timer expires: done wins
    core_lat = TO;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b1);
    wait_done();
    check1("done_beats_timeout", err, 1'b0);
    core_lat = 2;
    // abort on the third word
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_word(b[127:96]);
    send_word(b[95:64]);
    in_valid = 1'b1;
    in_data = b[63:32];
    abort = 1'b1;
    @(negedge clk);
    check1("abort_in_ready", in_ready, 1'b0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check1("abort_idle", busy, 1'b0);
    tick();
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b1);
    wait_done();
    // abort at output index 1
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    r = core_fn(b);
    send_block(b, 0, 1'b0);
    out_q.push_back({1'b0, r[127:96]});
    wait_valid();
    abort = 1'b1;
    @(negedge clk);
    check1("abort_no_shift", sr_shift, 1'b0);
    tick();
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_stream_idle", 128'({out_valid, busy}), 128'(2'b00));
      tick();
    end
    // reset at output index 2
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b1);
    wait_valid();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    out_q.delete();
    tick();
    // randomized traffic
    rand_bp = 1'b1;
    for (int n = 0; n < 20; n++) begin
      core_lat = int'($urandom_range(1, TO));
      send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 1'b1);
    end
    wait_done();
    rand_bp = 1'b0;
    check("blk_q_empty", 128'(blk_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_stream_sequencer.md
Name: aes_stream_sequencer

Overview:
- Control block between a 32-bit host word stream and the 128-bit AES128 core.
- Gathers four input words into a 128-bit block, then starts the core and waits for completion.
- Drives the 128-to-32 output shift register (load / shift / chip-select) and presents its four words MSB-first on a 32-bit valid/ready output stream.
- Output word data comes directly from the shift register's data_out. This block only generates the control and handshake signals.

Parameters:
- TIMEOUT, 64, maximum cycles spent in WAIT_CORE before the block flags an error (legal range 2..65535).

Ports:
- clk  input  1  main clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  32  host input word
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data
- abort  input  1  one-cycle request to drop the current operation
- aes_din  output  128  assembled block to the core
- aes_start  output  1  one-cycle start pulse to the core
- aes_done  input  1  core result valid; the core holds aes_dout stable until the next aes_start
- sr_load  output  1  load strobe to the shift register (it captures aes_dout)
- sr_shift  output  1  shift strobe to the shift register
- sr_cs  output  1  chip select to the shift register
- out_valid  output  1  shift register data_out carries a valid word
- out_last  output  1  current output word is the 4th
- out_ready  input  1  host accepts the output word
- busy  output  1  block is not in IDLE
- err  output  1  sticky core-timeout flag

Behaviour:
- Reset values: state IDLE; word counter 0; timer 0; aes_din 0; err 0.
- Reset values: in_ready 1; aes_start, sr_load, sr_shift, sr_cs, out_valid, out_last, busy all 0.
- FSM states: IDLE, GATHER, START, WAIT_CORE, LOAD, STREAM.
- IDLE / GATHER:
  - in_ready = 1.
  - An accept (in_valid && in_ready) writes the word into aes_din, first word at [127:96], second at [95:64], and so on. The counter then increments.
  - The first accept moves IDLE to GATHER.
  - The 4th accept moves to START on the next cycle. in_ready is 0 in every state after GATHER.
- START: aes_start = 1 for exactly one cycle, then WAIT_CORE with timer cleared. aes_din is held stable from START until the block returns to IDLE.
- WAIT_CORE:
  - Timer increments every cycle.
  - aes_done = 1 moves to LOAD.
  - If the timer reaches TIMEOUT-1 without aes_done: err is set, the block goes to IDLE, and the counter clears.
  - If aes_done and timeout occur in the same cycle, aes_done wins.
- LOAD: sr_load = 1 and sr_cs = 1 for one cycle, then STREAM. Latency from aes_done sampled high to the first out_valid is 2 cycles.
- STREAM:
  - out_valid = 1 and sr_cs = 1.
  - out_last = 1 when the output index is 3.
  - On each handshake (out_valid && out_ready), sr_shift = 1 combinationally in that cycle and the index increments.
  - The handshake at index 3 returns to IDLE and clears all counters.
  - out_valid stays high while out_ready is low, and the shift register contents do not change.
- sr_cs = 0 outside LOAD/STREAM. sr_load and sr_shift are never asserted together.
- busy = (state != IDLE).
- err stays set until reset, or until the next accepted first word in IDLE clears it.
- abort:
  - In any state, abort sampled high forces IDLE on the next cycle.
  - Counters and timer clear; err is unchanged; no aes_start or sr_load is issued in that cycle.
  - If abort and an in_valid accept fall in the same cycle, abort wins: in_ready is 0 that cycle.
  - If abort coincides with an out handshake, no sr_shift is issued.
- aes_done outside WAIT_CORE is ignored.
- Reset mid-operation returns to the full reset state on the next edge, regardless of state.
- Back-to-back blocks: the cycle after the final out handshake is IDLE with in_ready = 1. No extra bubble.

Test Plan:
- Basic block:
  - Stimulus: feed 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with in_valid held high; core model returns aes_done 5 cycles after start with dout 0x69C4E0D86A7B0430D8CDB78070B4C55A; out_ready held high.
  - Required: aes_din = 0x00112233_44556677_8899AABB_CCDDEEFF; exactly one aes_start; out words 0x69C4E0D8, 0x6A7B0430, 0xD8CDB780, 0x70B4C55A; out_last only on the 4th word; busy drops after it.
- Output backpressure:
  - Stimulus: out_ready low for 3 cycles during word 2.
  - Required: out_valid stays high, word 2 is unchanged, no sr_shift until out_ready rises, all 4 words are still delivered in order.
- Input gaps:
  - Stimulus: in_valid toggled 1,0,0,1,1,0,1.
  - Required: exactly 4 words captured in order; aes_start fires 1 cycle after the 4th accept.
- Timeout:
  - Stimulus: TIMEOUT=8, core never asserts aes_done.
  - Required: err = 1 exactly 8 cycles after entering WAIT_CORE; state IDLE; no sr_load.
  - Follow-up: the next first-word accept clears err.
- Abort cases:
  - Stimulus: abort on the same cycle as the 3rd word accept.
  - Required: that word is not accepted; IDLE next cycle.
  - Stimulus: abort at STREAM index 1.
  - Required: no further out_valid; no sr_shift in the abort cycle.
- Reset mid-stream:
  - Stimulus: reset asserted at STREAM index 2.
  - Required: next cycle has all outputs at reset values, in_ready = 1, err = 0.
